wb_arbiter: RTL

Writeback arbiter that drives the register file write port (regwrite/waddr/wdata) of the RISC-V core. It merges results from three producers into the single write port: ALU (single-cycle, no backpressure), load/store unit (LSU), and multiply/divide unit (MDU). LSU and MDU use valid/ready handshakes. Accepted results are registered, x0 writes are squashed, and MDU starvation is resolved by aging and a pipeline stall request.

---
 rtl/wb_arbiter.sv | 119 +++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU, LSU and MDU results onto the single register file write port.
// MDU starvation is bounded by an aging counter that flips LSU/MDU priority and requests an ALU stall.
module wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 32'd8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_data,
  input  logic        mdu_valid,
  output logic        mdu_ready,
  input  logic [4:0]  mdu_rd,
  input  logic [31:0] mdu_data,
  output logic        regwrite,
  output logic [4:0]  waddr,
  output logic [31:0] wdata,
  output logic        stall_req,
  output logic [31:0] wb_count
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic        grant_alu, grant_lsu, grant_mdu, promoted;
  logic [7:0]  starve_cnt_q, starve_cnt_d;
  logic        stall_q, stall_d;
  logic        regwrite_q, regwrite_d;
  logic [4:0]  waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] wb_count_q, wb_count_d;

  assign promoted = (starve_cnt_q >= LIMIT);

  // Grant selection: ALU always wins; MDU overtakes LSU once promoted
  always_comb begin
    grant_alu = alu_valid;
    grant_lsu = 1'b0;
    grant_mdu = 1'b0;
    if (!alu_valid) begin
      if (mdu_valid && (promoted || !lsu_valid)) begin
        grant_mdu = 1'b1;
      end else if (lsu_valid) begin
        grant_lsu = 1'b1;
      end else begin
        grant_mdu = 1'b0;
      end
    end else begin
      grant_lsu = 1'b0;
    end
  end

  assign lsu_ready = grant_lsu & resetn;
  assign mdu_ready = grant_mdu & resetn;

  // Next-state for the write port, aging counter and write counter
  always_comb begin
    regwrite_d   = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    case ({grant_alu, grant_lsu, grant_mdu})
      3'b100: begin
        waddr_d = alu_rd;
        wdata_d = alu_data;
      end
      3'b010: begin
        waddr_d = lsu_rd;
        wdata_d = lsu_data;
      end
      3'b001: begin
        waddr_d = mdu_rd;
        wdata_d = mdu_data;
      end
      default: begin
        waddr_d = waddr_q;
        wdata_d = wdata_q;
      end
    endcase
    // x0 results still complete their handshake but never write
    regwrite_d = (grant_alu | grant_lsu | grant_mdu) && (waddr_d != 5'd0);

    if (mdu_valid && !grant_mdu) begin
      starve_cnt_d = (starve_cnt_q == 8'd255) ? starve_cnt_q : starve_cnt_q + 8'd1;
    end else begin
      starve_cnt_d = 8'd0;
    end
    stall_d    = (starve_cnt_d >= LIMIT);
    wb_count_d = wb_count_q + {31'd0, regwrite_q};
  end

  // State registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      regwrite_q   <= 1'b0;
      waddr_q      <= 5'd0;
      wdata_q      <= 32'd0;
      starve_cnt_q <= 8'd0;
      stall_q      <= 1'b0;
      wb_count_q   <= 32'd0;
    end else begin
      regwrite_q   <= regwrite_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      starve_cnt_q <= starve_cnt_d;
      stall_q      <= stall_d;
      wb_count_q   <= wb_count_d;
    end
  end

  assign regwrite  = regwrite_q;
  assign waddr     = waddr_q;
  assign wdata     = wdata_q;
  assign stall_req = stall_q;
  assign wb_count  = wb_count_q;

endmodule
